// File: rtl/cnn_pool_pkg.sv
// rtl/cnn_pool_pkg.sv - shared pooling types and window-size helpers
package cnn_pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   localparam int POOL_K_MIN = 2;
   localparam int POOL_K_MAX = 4;

   function automatic int pool_win(input int k);
      return k * k;
   endfunction

   function automatic int pool_log2win(input int k);
      return $clog2(k * k);
   endfunction

endpackage

// File: rtl/pool_reduce_lane.sv
// rtl/pool_reduce_lane.sv - one channel's registered WIN->1 max/average reduction tree
module pool_reduce_lane
   import cnn_pool_pkg::*;
#(
   parameter int WIN        = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic                           en,
   input  logic                           mode_in,
   input  logic [WIN-1:0][DATA_WIDTH-1:0] win_in,
   output logic [DATA_WIDTH-1:0]          res
);

   localparam int LOG2WIN = $clog2(WIN);
   localparam int SW      = DATA_WIDTH + LOG2WIN;
   localparam int NODES   = 2 * WIN - 2;
   localparam logic [SW-1:0] RND = SW'(WIN / 2);

   // Stages 0..LOG2WIN-1 are packed into one flat array; stage s starts at stage_base(s).
   function automatic int stage_base(input int s);
      return 2 * WIN - 2 * (WIN >> s);
   endfunction

   function automatic logic [SW-1:0] combine(input logic [SW-1:0] a,
                                             input logic [SW-1:0] b,
                                             input logic          avg);
      if (avg)
         return a + b;
      return (a > b) ? a : b;
   endfunction

   logic [SW-1:0]         node_q [NODES];
   logic [SW-1:0]         node_d [NODES];
   logic [LOG2WIN-1:0]    mode_q;
   logic [SW-1:0]         last_sum;
   logic [SW-1:0]         last_max;
   logic [DATA_WIDTH-1:0] res_q;
   logic [DATA_WIDTH-1:0] res_d;

   always_comb begin
      for (int i = 0; i < NODES; i++)
         node_d[i] = '0;
      for (int e = 0; e < WIN; e++)
         node_d[e] = SW'(win_in[e]);
      for (int s = 1; s < LOG2WIN; s++)
         for (int e = 0; e < (WIN >> s); e++)
            node_d[stage_base(s) + e] = combine(node_q[stage_base(s - 1) + 2 * e],
                                                node_q[stage_base(s - 1) + 2 * e + 1],
                                                mode_q[s - 1] == POOL_AVG);
      // Rounding constant folds into the final add; WIN*max + WIN/2 still fits in SW bits.
      last_sum = combine(node_q[NODES - 2], node_q[NODES - 1], 1'b1) + RND;
      last_max = combine(node_q[NODES - 2], node_q[NODES - 1], 1'b0);
      res_d    = (mode_q[LOG2WIN - 1] == POOL_AVG) ? DATA_WIDTH'(last_sum >> LOG2WIN)
                                                   : DATA_WIDTH'(last_max);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NODES; i++)
            node_q[i] <= '0;
         mode_q <= '0;
         res_q  <= '0;
      end else if (en) begin
         for (int i = 0; i < NODES; i++)
            node_q[i] <= node_d[i];
         mode_q <= {mode_q[LOG2WIN-2:0], mode_in};
         res_q  <= res_d;
      end
   end

   assign res = res_q;

endmodule

// File: rtl/pooling_engine.sv
// rtl/pooling_engine.sv - KxK max/avg pooling over POOL_UNITS channels with valid/ready flow control
module pooling_engine
   import cnn_pool_pkg::*;
#(
   parameter int POOL_UNITS = 32,
   parameter int DATA_WIDTH = 8,
   parameter int K          = 2
) (
   input  logic                                          clk,
   input  logic                                          nrst,
   input  logic                                          flush,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic                                          in_mode,
   input  logic [POOL_UNITS-1:0][K*K-1:0][DATA_WIDTH-1:0] pool_in,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [POOL_UNITS-1:0][DATA_WIDTH-1:0]         pool_out,
   output logic                                          busy
);

   localparam int WIN     = pool_win(K);
   localparam int LOG2WIN = pool_log2win(K);

   generate
      if (K != POOL_K_MIN && K != POOL_K_MAX) begin : g_bad_k
         $error("pooling_engine: K=%0d unsupported, must be 2 or 4", K);
      end
   endgenerate

   logic [LOG2WIN:0] vld_q;
   logic             stall;
   logic             lane_en;
   logic             accept;

   assign stall    = out_valid & ~out_ready;
   assign lane_en  = ~stall;
   assign in_ready = ~stall & ~flush;
   assign accept   = in_valid & in_ready;

   // Single valid shift register shared by every lane; the lanes only see the advance enable.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         vld_q <= '0;
      else if (flush)
         vld_q <= '0;
      else if (lane_en)
         vld_q <= {vld_q[LOG2WIN-1:0], accept};
   end

   assign out_valid = vld_q[LOG2WIN];
   assign busy      = |vld_q;

   for (genvar u = 0; u < POOL_UNITS; u++) begin : g_lane
      pool_reduce_lane #(
         .WIN        (WIN),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk     (clk),
         .nrst    (nrst),
         .en      (lane_en),
         .mode_in (in_mode),
         .win_in  (pool_in[u]),
         .res     (pool_out[u])
      );
   end

endmodule

// File: tb/tb_pooling_engine.sv
// tb/tb_pooling_engine.sv - scoreboard bench for pooling_engine, K=2 and K=4 instances
module tb_pooling_engine;

   typedef logic [31:0][3:0][7:0] win2_t;
   typedef logic [3:0][15:0][7:0] win4_t;

   localparam int LAT2 = 3;
   localparam int LAT4 = 5;

   logic        clk;
   logic        nrst;

   logic        flush2, in_valid2, in_ready2, in_mode2, out_valid2, out_ready2, busy2;
   win2_t       pool_in2;
   logic [31:0][7:0] pool_out2;

   logic        flush4, in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, busy4;
   win4_t       pool_in4;
   logic [3:0][7:0] pool_out4;

   int          n_checks;
   int          n_fail;
   logic [255:0] exp_q2[$];
   logic [31:0]  exp_q4[$];
   logic         prev_stall2;
   logic [255:0] prev_out2;
   logic         rand_rdy;

   pooling_engine #(.POOL_UNITS(32), .DATA_WIDTH(8), .K(2)) u_k2 (
      .clk(clk), .nrst(nrst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_mode(in_mode2), .pool_in(pool_in2), .out_valid(out_valid2), .out_ready(out_ready2),
      .pool_out(pool_out2), .busy(busy2)
   );

   pooling_engine #(.POOL_UNITS(4), .DATA_WIDTH(8), .K(4)) u_k4 (
      .clk(clk), .nrst(nrst), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_mode(in_mode4), .pool_in(pool_in4), .out_valid(out_valid4), .out_ready(out_ready4),
      .pool_out(pool_out4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pool_ref(input logic [127:0] el, input int win, input logic m);
      int sum;
      int mx;
      sum = 0;
      mx  = 0;
      for (int i = 0; i < win; i++) begin
         sum += int'(el[i*8 +: 8]);
         if (int'(el[i*8 +: 8]) > mx)
            mx = int'(el[i*8 +: 8]);
      end
      return m ? 8'((sum + win / 2) / win) : 8'(mx);
   endfunction

   function automatic logic [255:0] model2(input win2_t w, input logic m);
      logic [255:0] r;
      for (int u = 0; u < 32; u++)
         r[u*8 +: 8] = pool_ref(128'(w[u]), 4, m);
      return r;
   endfunction

   function automatic logic [31:0] model4(input win4_t w, input logic m);
      logic [31:0] r;
      for (int u = 0; u < 4; u++)
         r[u*8 +: 8] = pool_ref(w[u], 16, m);
      return r;
   endfunction

   function automatic win2_t rand_win2();
      win2_t w;
      for (int u = 0; u < 32; u++)
         w[u] = $urandom();
      return w;
   endfunction

   // Scoreboard, handshake and stall-stability monitor, sampled on the falling edge.
   initial begin
      prev_stall2 = 1'b0;
      prev_out2   = '0;
      forever begin
         @(negedge clk);
         check("in_ready2", in_ready2, !(out_valid2 && !out_ready2) && !flush2);
         if (prev_stall2 && nrst) begin
            check("stall_valid", out_valid2, 1'b1);
            check("stall_hold", pool_out2, prev_out2);
         end
         if (out_valid2 && out_ready2) begin
            if (exp_q2.size() == 0)
               check("unexpected_out2", out_valid2, 1'b0);
            else
               check("pool_out2", pool_out2, exp_q2.pop_front());
         end
         if (out_valid4 && out_ready4) begin
            if (exp_q4.size() == 0)
               check("unexpected_out4", out_valid4, 1'b0);
            else
               check("pool_out4", pool_out4, exp_q4.pop_front());
         end
         prev_stall2 = out_valid2 && !out_ready2 && !flush2 && nrst;
         prev_out2   = pool_out2;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_rdy)
            out_ready2 = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "simulation timeout");
   end

   task automatic send2(input win2_t w, input logic m);
      int n;
      n = 0;
      pool_in2  = w;
      in_mode2  = m;
      in_valid2 = 1'b1;
      @(negedge clk);
      while (!in_ready2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_accept", in_ready2, 1'b1);
      exp_q2.push_back(model2(w, m));
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
   endtask

   task automatic single2(input string tag, input logic [31:0] win0, input logic m,
                          input logic [7:0] exp0);
      win2_t w;
      int    n;
      w    = rand_win2();
      w[0] = win0;
      pool_in2  = w;
      in_mode2  = m;
      in_valid2 = 1'b1;
      @(negedge clk);
      check({tag, "_ready"}, in_ready2, 1'b1);
      exp_q2.push_back(model2(w, m));
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid2 && n < 20);
      check({tag, "_lat"}, n, LAT2);
      check({tag, "_u0"}, pool_out2[0], exp0);
      @(posedge clk);
      #1;
   endtask

   task automatic single4(input string tag, input logic [127:0] win0, input logic m,
                          input logic [7:0] exp0);
      win4_t w;
      int    n;
      for (int u = 0; u < 4; u++)
         w[u] = {$urandom(), $urandom(), $urandom(), $urandom()};
      w[0] = win0;
      pool_in4  = w;
      in_mode4  = m;
      in_valid4 = 1'b1;
      @(negedge clk);
      check({tag, "_ready"}, in_ready4, 1'b1);
      exp_q4.push_back(model4(w, m));
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid4 && n < 20);
      check({tag, "_lat"}, n, LAT4);
      check({tag, "_u0"}, pool_out4[0], exp0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_fail   = 0;
      rand_rdy = 1'b0;
      nrst = 1'b0;
      flush2 = 1'b0; in_valid2 = 1'b0; in_mode2 = 1'b0; out_ready2 = 1'b1; pool_in2 = '0;
      flush4 = 1'b0; in_valid4 = 1'b0; in_mode4 = 1'b0; out_ready4 = 1'b1; pool_in4 = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid2", out_valid2, 1'b0);
      check("rst_busy2", busy2, 1'b0);
      check("rst_out2", pool_out2, '0);
      check("rst_valid4", out_valid4, 1'b0);
      check("rst_out4", pool_out4, '0);
      nrst = 1'b1;
      #1;
      check("rst_ready2", in_ready2, 1'b1);
      check("rst_ready4", in_ready4, 1'b1);
      @(posedge clk);
      #1;

      single2("k2_max", {8'd7, 8'd1, 8'd9, 8'd3}, 1'b0, 8'd9);
      single2("k2_avg_a", {8'd2, 8'd2, 8'd2, 8'd1}, 1'b1, 8'd2);
      single2("k2_avg_b", {8'd254, 8'd255, 8'd255, 8'd255}, 1'b1, 8'd255);
      single2("k2_avg_c", {8'd1, 8'd0, 8'd0, 8'd0}, 1'b1, 8'd0);
      single2("k2_avg_d", {8'd1, 8'd1, 8'd0, 8'd0}, 1'b1, 8'd1);

      single4("k4_avg", {16{8'd200}}, 1'b1, 8'd200);
      single4("k4_max", {8'd250, 120'd0}, 1'b0, 8'd250);

      rand_rdy = 1'b1;
      for (int i = 0; i < 8; i++)
         send2(rand_win2(), 1'(i % 2));
      rand_rdy   = 1'b0;
      out_ready2 = 1'b1;
      n = 0;
      while (exp_q2.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("stream_drain", exp_q2.size(), 0);
      @(posedge clk);
      #1;

      out_ready2 = 1'b0;
      for (int i = 0; i < 3; i++)
         send2(rand_win2(), 1'(i % 2));
      flush2    = 1'b1;
      in_valid2 = 1'b1;
      pool_in2  = rand_win2();
      @(negedge clk);
      check("flush_in_ready", in_ready2, 1'b0);
      @(posedge clk);
      #1;
      flush2    = 1'b0;
      in_valid2 = 1'b0;
      exp_q2.delete();
      check("flush_busy", busy2, 1'b0);
      check("flush_valid", out_valid2, 1'b0);
      out_ready2 = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("post_flush_valid", out_valid2, 1'b0);
      end
      @(posedge clk);
      #1;
      single2("after_flush", {8'd4, 8'd200, 8'd17, 8'd99}, 1'b0, 8'd200);

      send2(rand_win2(), 1'b0);
      send2(rand_win2(), 1'b1);
      #2;
      nrst = 1'b0;
      #1;
      check("arst_valid", out_valid2, 1'b0);
      check("arst_busy", busy2, 1'b0);
      check("arst_out", pool_out2, '0);
      exp_q2.delete();
      @(negedge clk);
      #2;
      nrst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("post_rst_valid", out_valid2, 1'b0);
      end
      @(posedge clk);
      #1;
      single2("after_rst", {8'd10, 8'd20, 8'd30, 8'd41}, 1'b1, 8'd25);

      repeat (4) @(posedge clk);
      #1;
      check("q2_empty", exp_q2.size(), 0);
      check("q4_empty", exp_q4.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
